fifo_writer: RTL and testbench

FIFO_WRITER -- requirements
Module: fifo_writer

---
 rtl/fifo_writer.sv | 130 +++++++++++++
 tb/tb_fifo_writer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_writer.sv
// fifo_writer: moves bytes from a shared holding register into an external
// FIFO using a parameterised setup / strobe / hold / recover write cycle.
module fifo_writer #(
  parameter int unsigned SETUP_TICKS   = 1,
  parameter int unsigned PULSE_TICKS   = 3,
  parameter int unsigned HOLD_TICKS    = 1,
  parameter int unsigned RECOVER_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nff,
  input  logic        src_data_avail,
  input  logic [7:0]  src_data,
  output logic        src_rd,
  output logic        fifo_nwr,
  output logic [7:0]  fifo_data_out,
  output logic        fifo_data_oe,
  output logic        busy,
  output logic [15:0] write_count
);

  localparam int unsigned TICK_W  = 8;
  localparam int unsigned COUNT_W = 16;

  // Last tick value of each phase; a phase lasts N cycles, counted from 0.
  localparam logic [TICK_W-1:0] SETUP_LAST   = TICK_W'(SETUP_TICKS - 1);
  localparam logic [TICK_W-1:0] PULSE_LAST   = TICK_W'(PULSE_TICKS - 1);
  localparam logic [TICK_W-1:0] HOLD_LAST    = TICK_W'(HOLD_TICKS - 1);
  localparam logic [TICK_W-1:0] RECOVER_LAST = TICK_W'(RECOVER_TICKS - 1);

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    WR_RECOVER
  } state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic                 src_rd_d;
  logic                 nwr_d;
  logic [7:0]           data_d;
  logic                 oe_d;
  logic                 busy_d;
  logic [COUNT_W-1:0]   count_d;

  // State, tick counter and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WR_IDLE;
      tick_q        <= '0;
      src_rd        <= 1'b0;
      fifo_nwr      <= 1'b1;
      fifo_data_out <= 8'h00;
      fifo_data_oe  <= 1'b0;
      busy          <= 1'b0;
      write_count   <= '0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      src_rd        <= src_rd_d;
      fifo_nwr      <= nwr_d;
      fifo_data_out <= data_d;
      fifo_data_oe  <= oe_d;
      busy          <= busy_d;
      write_count   <= count_d;
    end
  end

  // Next-state and next-output decode; inputs are only looked at in WR_IDLE.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q + TICK_W'(1);
    src_rd_d = 1'b0;
    nwr_d    = fifo_nwr;
    data_d   = fifo_data_out;
    oe_d     = fifo_data_oe;
    count_d  = write_count;

    unique case (state_q)
      WR_IDLE: begin
        tick_d = '0;
        if (src_data_avail && nff) begin
          data_d   = src_data;
          oe_d     = 1'b1;
          src_rd_d = 1'b1;
          state_d  = WR_SETUP;
        end
      end
      WR_SETUP: begin
        if (tick_q == SETUP_LAST) begin
          nwr_d   = 1'b0;
          tick_d  = '0;
          state_d = WR_STROBE;
        end
      end
      WR_STROBE: begin
        if (tick_q == PULSE_LAST) begin
          nwr_d   = 1'b1;
          tick_d  = '0;
          state_d = WR_HOLD;
        end
      end
      WR_HOLD: begin
        if (tick_q == HOLD_LAST) begin
          oe_d    = 1'b0;
          tick_d  = '0;
          state_d = WR_RECOVER;
        end
      end
      WR_RECOVER: begin
        if (tick_q == RECOVER_LAST) begin
          count_d = write_count + COUNT_W'(1);
          tick_d  = '0;
          state_d = WR_IDLE;
        end
      end
      default: begin
        nwr_d   = 1'b1;
        oe_d    = 1'b0;
        tick_d  = '0;
        state_d = WR_IDLE;
      end
    endcase

    busy_d = (state_d != WR_IDLE);
  end

endmodule

// File: tb/tb_fifo_writer.sv
// tb_fifo_writer: directed checks of the fifo_writer write cycle at default timing.
module tb_fifo_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        nff;
  logic        src_data_avail;
  logic [7:0]  src_data;
  logic        src_rd;
  logic        fifo_nwr;
  logic [7:0]  fifo_data_out;
  logic        fifo_data_oe;
  logic        busy;
  logic [15:0] write_count;

  int total = 0;
  int bad   = 0;

  fifo_writer dut (
    .clk            (clk),
    .rst            (rst),
    .nff            (nff),
    .src_data_avail (src_data_avail),
    .src_data       (src_data),
    .src_rd         (src_rd),
    .fifo_nwr       (fifo_nwr),
    .fifo_data_out  (fifo_data_out),
    .fifo_data_oe   (fifo_data_oe),
    .busy           (busy),
    .write_count    (write_count)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and sample 1 ns later; strobe must never be low with the bus released.
  task automatic step();
    @(posedge clk);
    #1;
    chk("nwr_needs_oe", 32'(!fifo_nwr && !fifo_data_oe), 32'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; nff = 1'b1; src_data_avail = 1'b0; src_data = 8'h00;
    steps(2);
    chk("rst_nwr",   32'(fifo_nwr),      32'd1);
    chk("rst_oe",    32'(fifo_data_oe),  32'd0);
    chk("rst_data",  32'(fifo_data_out), 32'h00);
    chk("rst_srcrd", 32'(src_rd),        32'd0);
    chk("rst_busy",  32'(busy),          32'd0);
    chk("rst_count", 32'(write_count),   32'd0);
    rst = 1'b0;
    step();

    // Single write of 8'hA5
    src_data_avail = 1'b1; src_data = 8'hA5;
    step();                                    // edge 0
    chk("s_e0_srcrd", 32'(src_rd),        32'd1);
    chk("s_e0_data",  32'(fifo_data_out), 32'hA5);
    chk("s_e0_oe",    32'(fifo_data_oe),  32'd1);
    chk("s_e0_nwr",   32'(fifo_nwr),      32'd1);
    chk("s_e0_busy",  32'(busy),          32'd1);
    src_data_avail = 1'b0; src_data = 8'h3C;
    step();                                    // edge 1
    chk("s_e1_srcrd", 32'(src_rd),   32'd0);
    chk("s_e1_nwr",   32'(fifo_nwr), 32'd0);
    step();
    chk("s_e2_nwr",   32'(fifo_nwr), 32'd0);
    step();
    chk("s_e3_nwr",   32'(fifo_nwr), 32'd0);
    chk("s_e3_data",  32'(fifo_data_out), 32'hA5);
    step();                                    // edge 4
    chk("s_e4_nwr",   32'(fifo_nwr),     32'd1);
    chk("s_e4_oe",    32'(fifo_data_oe), 32'd1);
    step();                                    // edge 5
    chk("s_e5_oe",    32'(fifo_data_oe),  32'd0);
    chk("s_e5_data",  32'(fifo_data_out), 32'hA5);
    step();
    chk("s_e6_count", 32'(write_count), 32'd0);
    chk("s_e6_busy",  32'(busy),        32'd1);
    step();                                    // edge 7
    chk("s_e7_count", 32'(write_count), 32'd1);
    chk("s_e7_busy",  32'(busy),        32'd0);
    step();
    chk("s_idle_srcrd", 32'(src_rd), 32'd0);

    // Back-to-back writes 8'h01 then 8'h02
    src_data_avail = 1'b1; src_data = 8'h01;
    step();                                    // edge 0
    chk("b_e0_srcrd", 32'(src_rd),        32'd1);
    chk("b_e0_data",  32'(fifo_data_out), 32'h01);
    src_data = 8'h02;
    step();
    chk("b_e1_srcrd", 32'(src_rd), 32'd0);
    steps(2);
    chk("b_e3_data",  32'(fifo_data_out), 32'h01);
    steps(4);                                  // edge 7
    chk("b_e7_count", 32'(write_count), 32'd2);
    chk("b_e7_srcrd", 32'(src_rd),      32'd0);
    step();                                    // edge 8
    chk("b_e8_srcrd", 32'(src_rd),        32'd1);
    chk("b_e8_data",  32'(fifo_data_out), 32'h02);
    src_data_avail = 1'b0;
    steps(7);                                  // edge 15
    chk("b_e15_count", 32'(write_count), 32'd3);
    chk("b_e15_busy",  32'(busy),        32'd0);

    // FIFO full holds the writer idle
    nff = 1'b0; src_data_avail = 1'b1; src_data = 8'h77;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("f_srcrd", 32'(src_rd), 32'd0);
    end
    chk("f_nwr",  32'(fifo_nwr), 32'd1);
    chk("f_busy", 32'(busy),     32'd0);
    nff = 1'b1;
    step();                                    // edge 0
    chk("f_start_srcrd", 32'(src_rd),        32'd1);
    chk("f_start_data",  32'(fifo_data_out), 32'h77);

    // FIFO goes full mid-write; write completes, next waits
    step();                                    // edge 1
    chk("m_e1_nwr", 32'(fifo_nwr), 32'd0);
    nff = 1'b0;
    step();
    chk("m_e2_nwr", 32'(fifo_nwr), 32'd0);
    step();
    chk("m_e3_nwr", 32'(fifo_nwr), 32'd0);
    step();
    chk("m_e4_nwr", 32'(fifo_nwr), 32'd1);
    steps(3);                                  // edge 7
    chk("m_e7_count", 32'(write_count), 32'd4);
    step();                                    // edge 8
    chk("m_e8_srcrd", 32'(src_rd), 32'd0);
    chk("m_e8_busy",  32'(busy),   32'd0);
    steps(3);
    chk("m_wait_busy", 32'(busy), 32'd0);
    nff = 1'b1; src_data = 8'hC3;
    step();
    chk("m_resume_srcrd", 32'(src_rd),        32'd1);
    chk("m_resume_data",  32'(fifo_data_out), 32'hC3);
    src_data_avail = 1'b0;

    // Reset during the strobe
    steps(2);
    chk("r_strobe_nwr", 32'(fifo_nwr), 32'd0);
    rst = 1'b1;
    step();
    chk("r_nwr",   32'(fifo_nwr),     32'd1);
    chk("r_oe",    32'(fifo_data_oe), 32'd0);
    chk("r_count", 32'(write_count),  32'd0);
    chk("r_busy",  32'(busy),         32'd0);
    rst = 1'b0;
    steps(2);

    // write_count wrap from 16'hFFFF
    force dut.write_count = 16'hFFFF;
    #1;
    release dut.write_count;
    src_data_avail = 1'b1; src_data = 8'h5A;
    step();                                    // edge 0
    chk("w_e0_srcrd", 32'(src_rd), 32'd1);
    src_data_avail = 1'b0;
    steps(6);                                  // edge 6
    chk("w_e6_count", 32'(write_count), 32'hFFFF);
    step();                                    // edge 7
    chk("w_e7_count", 32'(write_count), 32'h0000);
    chk("w_e7_busy",  32'(busy),        32'd0);
    steps(3);
    chk("w_after_count", 32'(write_count), 32'h0000);
    chk("w_after_nwr",   32'(fifo_nwr),    32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
